// File: rtl/flags_cond_unit_if.sv
// flags_cond_unit_if
// EX-stage request signals and MEM-stage result signals for flags_cond_unit.
// The pipeline (master) drives the EX side and stall/flush controls; the
// flags/condition unit (slave) returns the held flags, the registered branch
// decision and the B.cond statistics counters.

interface flags_cond_unit_if #(
    parameter int unsigned CNT_W = 32
);
    logic             stall;
    logic             flush;
    logic             ex_valid;
    logic             write_flags;
    logic [3:0]       CPSR_flags;
    logic             ex_bcond;
    logic [3:0]       ex_cond;
    logic [63:0]      ex_branch_target;
    logic             cnt_clear;

    logic [3:0]       flags_q;
    logic             mem_valid;
    logic             mem_bcond_taken;
    logic [63:0]      mem_branch_target;
    logic [CNT_W-1:0] taken_count;
    logic [CNT_W-1:0] not_taken_count;

    modport master (
        output stall,
        output flush,
        output ex_valid,
        output write_flags,
        output CPSR_flags,
        output ex_bcond,
        output ex_cond,
        output ex_branch_target,
        output cnt_clear,
        input  flags_q,
        input  mem_valid,
        input  mem_bcond_taken,
        input  mem_branch_target,
        input  taken_count,
        input  not_taken_count
    );

    modport slave (
        input  stall,
        input  flush,
        input  ex_valid,
        input  write_flags,
        input  CPSR_flags,
        input  ex_bcond,
        input  ex_cond,
        input  ex_branch_target,
        input  cnt_clear,
        output flags_q,
        output mem_valid,
        output mem_bcond_taken,
        output mem_branch_target,
        output taken_count,
        output not_taken_count
    );
endinterface

// File: rtl/flags_cond_unit.sv
// flags_cond_unit
// Sits behind the EX-stage ALU of the pipelined LEGv8 core. Holds the
// architectural NZCV flags (bit order [3]=Z [2]=N [1]=C [0]=V), evaluates
// B.cond conditions against the held flags, registers the branch decision
// and target across the EX/MEM boundary, and keeps saturating counters of
// taken and not-taken B.cond instructions.
// A B.cond sees the flags as they were before any update in the same cycle;
// there is no forwarding from CPSR_flags.

module flags_cond_unit #(
    parameter int unsigned CNT_W     = 32,
    parameter logic [3:0]  FLAGS_RST = 4'b0000
) (
    input logic              clk,
    input logic              reset,
    flags_cond_unit_if.slave bus
);

    localparam logic [3:0] cond_eq = 4'b0000;
    localparam logic [3:0] cond_ne = 4'b0001;
    localparam logic [3:0] cond_hs = 4'b0010;
    localparam logic [3:0] cond_lo = 4'b0011;
    localparam logic [3:0] cond_mi = 4'b0100;
    localparam logic [3:0] cond_pl = 4'b0101;
    localparam logic [3:0] cond_vs = 4'b0110;
    localparam logic [3:0] cond_vc = 4'b0111;
    localparam logic [3:0] cond_hi = 4'b1000;
    localparam logic [3:0] cond_ls = 4'b1001;
    localparam logic [3:0] cond_ge = 4'b1010;
    localparam logic [3:0] cond_lt = 4'b1011;
    localparam logic [3:0] cond_gt = 4'b1100;
    localparam logic [3:0] cond_le = 4'b1101;

    localparam logic [CNT_W-1:0] cnt_zero = '0;
    localparam logic [CNT_W-1:0] cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] cnt_max  = '1;

    logic [3:0]       flags_r;
    logic             mem_valid_r;
    logic             mem_taken_r;
    logic [63:0]      mem_target_r;
    logic [CNT_W-1:0] taken_r;
    logic [CNT_W-1:0] not_taken_r;

    logic             accept;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic             flag_v;
    logic             cond_true;
    logic             bcond_accept;

    assign accept       = bus.ex_valid & ~bus.stall & ~bus.flush;
    assign bcond_accept = accept & bus.ex_bcond;

    assign flag_z = flags_r[3];
    assign flag_n = flags_r[2];
    assign flag_c = flags_r[1];
    assign flag_v = flags_r[0];

    // Evaluate the B.cond condition field against the currently held flags.
    always_comb begin
        cond_true = 1'b1;
        case (bus.ex_cond)
            cond_eq: cond_true = flag_z;
            cond_ne: cond_true = ~flag_z;
            cond_hs: cond_true = flag_c;
            cond_lo: cond_true = ~flag_c;
            cond_mi: cond_true = flag_n;
            cond_pl: cond_true = ~flag_n;
            cond_vs: cond_true = flag_v;
            cond_vc: cond_true = ~flag_v;
            cond_hi: cond_true = flag_c & ~flag_z;
            cond_ls: cond_true = ~(flag_c & ~flag_z);
            cond_ge: cond_true = (flag_n == flag_v);
            cond_lt: cond_true = (flag_n != flag_v);
            cond_gt: cond_true = ~flag_z & (flag_n == flag_v);
            cond_le: cond_true = ~(~flag_z & (flag_n == flag_v));
            default: cond_true = 1'b1;
        endcase
    end

    // Architectural NZCV register: load from the ALU only for an accepted flag-setting instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_r <= FLAGS_RST;
        end else if (accept && bus.write_flags) begin
            flags_r <= bus.CPSR_flags;
        end
    end

    // EX/MEM boundary: flush squashes the instruction (target held), stall freezes, otherwise advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_valid_r  <= 1'b0;
            mem_taken_r  <= 1'b0;
            mem_target_r <= 64'd0;
        end else if (bus.flush) begin
            mem_valid_r <= 1'b0;
            mem_taken_r <= 1'b0;
        end else if (!bus.stall) begin
            mem_valid_r  <= bus.ex_valid;
            mem_taken_r  <= bus.ex_valid & bus.ex_bcond & cond_true;
            mem_target_r <= bus.ex_branch_target;
        end
    end

    // Saturating taken counter; the statistics clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            taken_r <= cnt_zero;
        end else if (bus.cnt_clear) begin
            taken_r <= cnt_zero;
        end else if (bcond_accept && cond_true && (taken_r != cnt_max)) begin
            taken_r <= taken_r + cnt_one;
        end
    end

    // Saturating not-taken counter; the statistics clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            not_taken_r <= cnt_zero;
        end else if (bus.cnt_clear) begin
            not_taken_r <= cnt_zero;
        end else if (bcond_accept && !cond_true && (not_taken_r != cnt_max)) begin
            not_taken_r <= not_taken_r + cnt_one;
        end
    end

    assign bus.flags_q           = flags_r;
    assign bus.mem_valid         = mem_valid_r;
    assign bus.mem_bcond_taken   = mem_taken_r;
    assign bus.mem_branch_target = mem_target_r;
    assign bus.taken_count       = taken_r;
    assign bus.not_taken_count   = not_taken_r;

endmodule

// File: tb/tb_flags_cond_unit.sv
// tb_flags_cond_unit
// Self-checking bench for flags_cond_unit with a small behavioural model of
// the flags register, EX/MEM boundary and saturating B.cond counters.

module tb_flags_cond_unit;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    flags_cond_unit_if #(.CNT_W(CNT_W)) bus_if ();

    flags_cond_unit #(
        .CNT_W    (CNT_W),
        .FLAGS_RST(4'b0000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if.slave)
    );

    always #5 clk = ~clk;

    logic [3:0]  m_flags;
    logic        m_valid;
    logic        m_taken;
    logic [63:0] m_target;
    int          m_tc;
    int          m_ntc;

    // ARM-style condition: a base test chosen by cond[3:1], inverted by cond[0].
    function automatic logic cond_model(input logic [3:0] f, input logic [3:0] c);
        logic z, n, cf, v, base;
        {z, n, cf, v} = f;
        if (c[3:1] == 3'b111) return 1'b1;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cf;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cf && !z;
            3'd5:    base = (n == v);
            default: base = (n == v) && !z;
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic model_reset();
        m_flags  = 4'b0000;
        m_valid  = 1'b0;
        m_taken  = 1'b0;
        m_target = 64'd0;
        m_tc     = 0;
        m_ntc    = 0;
    endtask

    task automatic model_step();
        logic acc, ct;
        acc = bus_if.ex_valid && !bus_if.stall && !bus_if.flush;
        ct  = cond_model(m_flags, bus_if.ex_cond);
        if (bus_if.flush) begin
            m_valid = 1'b0;
            m_taken = 1'b0;
        end else if (!bus_if.stall) begin
            m_valid  = bus_if.ex_valid;
            m_target = bus_if.ex_branch_target;
            m_taken  = bus_if.ex_valid && bus_if.ex_bcond && ct;
        end
        if (bus_if.cnt_clear) begin
            m_tc  = 0;
            m_ntc = 0;
        end else if (acc && bus_if.ex_bcond) begin
            if (ct) m_tc = (m_tc < CNT_MAX) ? m_tc + 1 : CNT_MAX;
            else    m_ntc = (m_ntc < CNT_MAX) ? m_ntc + 1 : CNT_MAX;
        end
        if (acc && bus_if.write_flags) m_flags = bus_if.CPSR_flags;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_step();
        else       model_reset();
        #1;
    endtask

    task automatic drive_idle();
        bus_if.stall            = 1'b0;
        bus_if.flush            = 1'b0;
        bus_if.ex_valid         = 1'b0;
        bus_if.write_flags      = 1'b0;
        bus_if.CPSR_flags       = 4'b0000;
        bus_if.ex_bcond         = 1'b0;
        bus_if.ex_cond          = 4'b0000;
        bus_if.ex_branch_target = 64'd0;
        bus_if.cnt_clear        = 1'b0;
    endtask

    task automatic drive_op(input logic wf, input logic [3:0] cpsr, input logic bc,
                            input logic [3:0] cond, input logic [63:0] target);
        drive_idle();
        bus_if.ex_valid         = 1'b1;
        bus_if.write_flags      = wf;
        bus_if.CPSR_flags       = cpsr;
        bus_if.ex_bcond         = bc;
        bus_if.ex_cond          = cond;
        bus_if.ex_branch_target = target;
    endtask

    task automatic drive_random();
        bus_if.stall            = ($urandom_range(0, 3) == 0);
        bus_if.flush            = ($urandom_range(0, 7) == 0);
        bus_if.ex_valid         = ($urandom_range(0, 3) != 0);
        bus_if.write_flags      = ($urandom_range(0, 2) == 0);
        bus_if.CPSR_flags       = 4'($urandom);
        bus_if.ex_bcond         = ($urandom_range(0, 1) == 1);
        bus_if.ex_cond          = 4'($urandom);
        bus_if.ex_branch_target = {$urandom, $urandom};
        bus_if.cnt_clear        = !bus_if.stall && ($urandom_range(0, 15) == 0);
    endtask

    task automatic clear_counters();
        drive_idle();
        bus_if.cnt_clear = 1'b1;
        tick();
        bus_if.cnt_clear = 1'b0;
    endtask

    task automatic test_reset();
        logic [77:0] obs;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_random();
            tick();
        end
        obs = {bus_if.flags_q, bus_if.mem_valid, bus_if.mem_bcond_taken, bus_if.mem_branch_target,
               bus_if.taken_count, bus_if.not_taken_count};
        checks++;
        if (obs !== 78'd0) begin
            $display("FAIL reset_state: got %h expected %h", obs, 78'd0);
            errors++;
        end
        reset = 1'b1;
        drive_op(1'b1, 4'b0110, 1'b1, 4'b0000, 64'h1234);
        tick();
        obs = {bus_if.flags_q, bus_if.mem_valid, bus_if.mem_bcond_taken, bus_if.mem_branch_target,
               bus_if.taken_count, bus_if.not_taken_count};
        checks++;
        if (obs !== {4'b0110, 1'b1, 1'b0, 64'h1234, 4'd0, 4'd1}) begin
            $display("FAIL first_accept_after_reset: got %h expected %h", obs,
                     {4'b0110, 1'b1, 1'b0, 64'h1234, 4'd0, 4'd1});
            errors++;
        end
    endtask

    task automatic test_subs_beq();
        clear_counters();
        drive_op(1'b1, 4'b1000, 1'b0, 4'b0000, 64'd0);
        tick();
        drive_op(1'b0, 4'b0000, 1'b1, 4'b0000, 64'h40);
        tick();
        checks++;
        if ({bus_if.mem_bcond_taken, bus_if.mem_branch_target, bus_if.taken_count, bus_if.flags_q}
            !== {1'b1, 64'h40, 4'd1, 4'b1000}) begin
            $display("FAIL subs_beq: got taken=%b target=%h tc=%0d flags=%b expected 1 40 1 1000",
                     bus_if.mem_bcond_taken, bus_if.mem_branch_target, bus_if.taken_count, bus_if.flags_q);
            errors++;
        end
    endtask

    task automatic test_ge_lt_gt();
        clear_counters();
        drive_op(1'b1, 4'b0101, 1'b0, 4'b0000, 64'd0);
        tick();
        drive_op(1'b0, 4'b0000, 1'b1, 4'b1010, 64'h100);
        tick();
        checks++;
        if (bus_if.mem_bcond_taken !== 1'b1) begin
            $display("FAIL b_ge: got %b expected 1", bus_if.mem_bcond_taken);
            errors++;
        end
        drive_op(1'b0, 4'b0000, 1'b1, 4'b1011, 64'h200);
        tick();
        checks++;
        if ({bus_if.mem_bcond_taken, bus_if.not_taken_count} !== {1'b0, 4'd1}) begin
            $display("FAIL b_lt: got taken=%b ntc=%0d expected 0 1", bus_if.mem_bcond_taken,
                     bus_if.not_taken_count);
            errors++;
        end
        drive_op(1'b0, 4'b0000, 1'b1, 4'b1100, 64'h300);
        tick();
        checks++;
        if ({bus_if.mem_bcond_taken, bus_if.taken_count} !== {1'b1, 4'd2}) begin
            $display("FAIL b_gt: got taken=%b tc=%0d expected 1 2", bus_if.mem_bcond_taken,
                     bus_if.taken_count);
            errors++;
        end
    endtask

    task automatic test_stall_flush();
        drive_op(1'b1, 4'b0010, 1'b1, 4'b1110, 64'hDEAD);
        bus_if.stall = 1'b1;
        tick();
        checks++;
        if ({bus_if.flags_q, bus_if.mem_valid, bus_if.mem_bcond_taken, bus_if.mem_branch_target,
             bus_if.taken_count, bus_if.not_taken_count} !== {4'b0101, 1'b1, 1'b1, 64'h300, 4'd2, 4'd1}) begin
            $display("FAIL stall_hold: got flags=%b v=%b t=%b tgt=%h tc=%0d ntc=%0d expected 0101 1 1 300 2 1",
                     bus_if.flags_q, bus_if.mem_valid, bus_if.mem_bcond_taken,
                     bus_if.mem_branch_target, bus_if.taken_count, bus_if.not_taken_count);
            errors++;
        end
        bus_if.flush = 1'b1;
        tick();
        checks++;
        if ({bus_if.flags_q, bus_if.mem_valid, bus_if.mem_bcond_taken, bus_if.mem_branch_target,
             bus_if.taken_count, bus_if.not_taken_count} !== {4'b0101, 1'b0, 1'b0, 64'h300, 4'd2, 4'd1}) begin
            $display("FAIL stall_flush: got flags=%b v=%b t=%b tgt=%h tc=%0d ntc=%0d expected 0101 0 0 300 2 1",
                     bus_if.flags_q, bus_if.mem_valid, bus_if.mem_bcond_taken,
                     bus_if.mem_branch_target, bus_if.taken_count, bus_if.not_taken_count);
            errors++;
        end
        drive_idle();
    endtask

    task automatic test_saturation();
        clear_counters();
        for (int i = 0; i < 16; i++) begin
            drive_op(1'b0, 4'b0000, 1'b1, 4'b1110, 64'(i));
            tick();
        end
        checks++;
        if (bus_if.taken_count !== 4'hF) begin
            $display("FAIL saturate_16: got %h expected f", bus_if.taken_count);
            errors++;
        end
        drive_op(1'b0, 4'b0000, 1'b1, 4'b1111, 64'h77);
        tick();
        checks++;
        if ({bus_if.taken_count, bus_if.mem_bcond_taken} !== {4'hF, 1'b1}) begin
            $display("FAIL saturate_hold: got tc=%h taken=%b expected f 1", bus_if.taken_count,
                     bus_if.mem_bcond_taken);
            errors++;
        end
        drive_op(1'b0, 4'b0000, 1'b1, 4'b1110, 64'h88);
        bus_if.cnt_clear = 1'b1;
        tick();
        checks++;
        if ({bus_if.taken_count, bus_if.not_taken_count} !== 8'h00) begin
            $display("FAIL clear_over_inc: got tc=%h ntc=%h expected 0 0", bus_if.taken_count,
                     bus_if.not_taken_count);
            errors++;
        end
        drive_idle();
    endtask

    task automatic test_all_conds();
        logic exp;
        for (int f = 0; f < 16; f++) begin
            drive_op(1'b1, 4'(f), 1'b0, 4'b0000, 64'd0);
            tick();
            for (int c = 0; c < 16; c++) begin
                drive_op(1'b0, 4'b0000, 1'b1, 4'(c), {$urandom, $urandom});
                tick();
                exp = cond_model(4'(f), 4'(c));
                checks++;
                if (bus_if.mem_bcond_taken !== exp) begin
                    $display("FAIL cond_table flags=%b cond=%b: got %b expected %b", 4'(f), 4'(c),
                             bus_if.mem_bcond_taken, exp);
                    errors++;
                end
            end
        end
        drive_idle();
    endtask

    task automatic test_random();
        logic [77:0] obs, exp;
        clear_counters();
        for (int i = 0; i < 400; i++) begin
            drive_random();
            tick();
            obs = {bus_if.flags_q, bus_if.mem_valid, bus_if.mem_bcond_taken, bus_if.mem_branch_target,
                   bus_if.taken_count, bus_if.not_taken_count};
            exp = {m_flags, m_valid, m_taken, m_target, 4'(m_tc), 4'(m_ntc)};
            checks++;
            if (obs !== exp) begin
                $display("FAIL random cycle %0d: got %h expected %h", i, obs, exp);
                errors++;
            end
        end
        drive_idle();
    endtask

    task automatic test_reset_mid_stall();
        logic [77:0] obs;
        drive_op(1'b1, 4'b1111, 1'b1, 4'b1110, 64'h55);
        tick();
        bus_if.stall = 1'b1;
        bus_if.flush = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        obs = {bus_if.flags_q, bus_if.mem_valid, bus_if.mem_bcond_taken, bus_if.mem_branch_target,
               bus_if.taken_count, bus_if.not_taken_count};
        checks++;
        if (obs !== 78'd0) begin
            $display("FAIL async_reset_mid_stall: got %h expected %h", obs, 78'd0);
            errors++;
        end
        tick();
        reset = 1'b1;
        drive_op(1'b1, 4'b0011, 1'b1, 4'b0011, 64'h99);
        tick();
        checks++;
        if ({bus_if.flags_q, bus_if.mem_valid, bus_if.mem_bcond_taken, bus_if.mem_branch_target}
            !== {4'b0011, 1'b1, 1'b1, 64'h99}) begin
            $display("FAIL resume_after_reset: got flags=%b v=%b t=%b tgt=%h expected 0011 1 1 99",
                     bus_if.flags_q, bus_if.mem_valid, bus_if.mem_bcond_taken, bus_if.mem_branch_target);
            errors++;
        end
        drive_idle();
    endtask

    initial begin
        reset = 1'b0;
        drive_idle();
        model_reset();
        #3;
        test_reset();
        test_subs_beq();
        test_ge_lt_gt();
        test_stall_flush();
        test_saturation();
        test_all_conds();
        test_random();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
